// File: rtl/cpu_ask2_nios2_qsys_0_div_cell.sv
// Iterative radix-2 restoring divider: IDLE -> PREP -> WIDTH x ITER -> FIX,
// returning truncating (C-style) signed or plain unsigned quotient/remainder.
module cpu_ask2_nios2_qsys_0_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] M_div_src1,
  input  logic [WIDTH-1:0] M_div_src2,
  input  logic             M_div_signed,
  input  logic             M_div_start,
  output logic             M_div_busy,
  output logic             M_div_done,
  output logic [WIDTH-1:0] M_div_quotient,
  output logic [WIDTH-1:0] M_div_remainder
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] src1_q, src1_d, src2_q, src2_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d, remo_q, remo_d;
  logic             done_q, done_d;

  logic             neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   rem_sh, diff;

  assign neg1 = sgn_q & src1_q[WIDTH-1];
  assign neg2 = sgn_q & src2_q[WIDTH-1];
  assign mag1 = neg1 ? (~src1_q + 1'b1) : src1_q;
  assign mag2 = neg2 ? (~src2_q + 1'b1) : src2_q;

  // Partial remainder is always < divisor, so the shifted value fits WIDTH+1 bits
  // and diff[WIDTH] is the borrow of the trial subtract.
  assign rem_sh = {rem_q, dq_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvsr_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    sgn_d   = sgn_q;
    dvsr_d  = dvsr_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (M_div_start) begin
          src1_d  = M_div_src1;
          src2_d  = M_div_src2;
          sgn_d   = M_div_signed;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        qneg_d  = sgn_q & (src1_q[WIDTH-1] ^ src2_q[WIDTH-1]);
        rneg_d  = neg1;
        dz_d    = (src2_q == '0);
        cnt_d   = CW'(WIDTH-1);
        rem_d   = '0;
        dq_d    = mag1;
        dvsr_d  = mag2;
        state_d = S_ITER;
      end
      S_ITER: begin
        rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        dq_d  = {dq_q[WIDTH-2:0], ~diff[WIDTH]};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        if (dz_q) begin
          quot_d = '1;
          remo_d = src1_q;
        end else begin
          quot_d = qneg_q ? (~dq_q + 1'b1) : dq_q;
          remo_d = rneg_q ? (~rem_q + 1'b1) : rem_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      sgn_q   <= 1'b0;
      dvsr_q  <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      sgn_q   <= sgn_d;
      dvsr_q  <= dvsr_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      done_q  <= done_d;
    end
  end

  assign M_div_busy      = (state_q != S_IDLE);
  assign M_div_done      = done_q;
  assign M_div_quotient  = quot_q;
  assign M_div_remainder = remo_q;

endmodule

// File: tb/tb_cpu_ask2_nios2_qsys_0_div_cell.sv
// Bench for the iterative divider: directed corner cases plus random operands,
// checked cycle by cycle against an arithmetic reference model.
module tb_cpu_ask2_nios2_qsys_0_div_cell;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk, reset;
  logic [W-1:0] src1, src2;
  logic         sgn, start;
  logic         busy, done;
  logic [W-1:0] quot, rem;

  int vectors = 0;
  int miss    = 0;
  logic [W-1:0] prev_q = '0, prev_r = '0;

  cpu_ask2_nios2_qsys_0_div_cell #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .M_div_src1      (src1),
    .M_div_src2      (src2),
    .M_div_signed    (sgn),
    .M_div_start     (start),
    .M_div_busy      (busy),
    .M_div_done      (done),
    .M_div_quotient  (quot),
    .M_div_remainder (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // C-style truncating division computed in 64-bit arithmetic, so the
  // most-negative / -1 case simply wraps when cut back to W bits.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb, tq, tr;
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      tq = sa / sb;
      tr = sa % sb;
      q  = tq[W-1:0];
      r  = tr[W-1:0];
    end
  endtask

  // Starts an op at the next edge (edge 0) and follows it to the done edge.
  // Stray starts at edges 5 and 20 and operand changes after edge 0 must not matter.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] eq, er;
    model(a, b, s, eq, er);
    src1 = a; src2 = b; sgn = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_edge0", {31'd0, busy}, 1);
    chk("q_hold_edge0", quot, prev_q);
    chk("r_hold_edge0", rem, prev_r);
    src1 = $urandom; src2 = $urandom; sgn = 1'($urandom_range(0, 1));
    for (int i = 1; i <= LAT; i++) begin
      if (i == 5 || i == 20) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (i < LAT) begin
        chk("busy_iter", {31'd0, busy}, 1);
        chk("done_early", {31'd0, done}, 0);
      end else begin
        chk("busy_done", {31'd0, busy}, 0);
        chk("done_pulse", {31'd0, done}, 1);
        chk("quotient", quot, eq);
        chk("remainder", rem, er);
      end
    end
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    reset = 1'b1; start = 1'b0; src1 = '0; src2 = '0; sgn = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_q", quot, 0);
    chk("rst_r", rem, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed corner cases, issued back to back (start coincides with done)
    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFF9, 32'h2, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(32'd5, 32'd0, 1'b0);
    run_op(32'hFFFF_FFFB, 32'd0, 1'b1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1);

    // Idle gap: done stays low and results hold
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle_done", {31'd0, done}, 0);
      chk("idle_q_hold", quot, prev_q);
      chk("idle_r_hold", rem, prev_r);
    end

    for (int n = 0; n < 16; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0, 1:    rb = $urandom;
        2:       rb = W'($urandom_range(1, 255));
        3:       rb = -W'($urandom_range(1, 255));
        default: rb = '0;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs);
    end

    // Reset at edge 10 of an operation aborts it
    src1 = 32'd1000; src2 = 32'd3; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_q", quot, 0);
    chk("abort_r", rem, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("post_abort_done", {31'd0, done}, 0);
      chk("post_abort_busy", {31'd0, busy}, 0);
    end
    prev_q = '0;
    prev_r = '0;
    run_op(32'hFFFF_FFFF, 32'h10, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
